// File: rtl/noc_output_port_buf.sv
// NoC router output port: DEPTH-entry flit FIFO feeding a registered link stage,
// with neighbour backpressure (ret), full indication, sticky overflow and stall watchdog.
module noc_output_port_buf #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int ZERO_IDLE   = 1,
  parameter int STALL_LIMIT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       full_ret,
  input  logic                       ret,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf_err,
  output logic                       stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STALL_LIMIT+1);

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);
  localparam logic [SW-1:0] STALL_ONE = SW'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_valid_r;
  logic                  ovf_err_r;
  logic [SW-1:0]         stall_cnt_r;
  logic                  stall_r;

  logic                  idle_s;
  logic                  full_s;
  logic                  push_s;
  logic                  ovf_s;
  logic                  xfer_s;
  logic                  free_s;
  logic                  pop_s;
  logic [CW-1:0]         count_nxt_s;
  logic [DATA_WIDTH-1:0] out_data_nxt_s;
  logic                  out_valid_nxt_s;
  logic [SW-1:0]         stall_cnt_nxt_s;
  logic                  stall_nxt_s;

  // Handshake qualification; a push is refused when full even if a pop happens too.
  always_comb begin
    idle_s = (ZERO_IDLE != 0) && (in_data == {DATA_WIDTH{1'b0}});
    full_s = (count_r == FULL_CNT);
    push_s = in_valid && !full_s && !idle_s;
    ovf_s  = in_valid && full_s && !idle_s;
    xfer_s = out_valid_r && !ret;
    free_s = !out_valid_r || xfer_s;
    pop_s  = free_s && (count_r != {CW{1'b0}});
  end

  // Occupancy update from the push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Output register: reload on pop, go idle when drained, hold under backpressure.
  always_comb begin
    out_data_nxt_s  = out_data_r;
    out_valid_nxt_s = out_valid_r;
    if (pop_s) begin
      out_data_nxt_s  = mem_r[rd_ptr_r];
      out_valid_nxt_s = 1'b1;
    end else if (free_s) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Stall watchdog: saturating run-length of blocked cycles.
  always_comb begin
    stall_cnt_nxt_s = {SW{1'b0}};
    if (out_valid_r && ret) begin
      if (stall_cnt_r == STALL_MAX) begin
        stall_cnt_nxt_s = STALL_MAX;
      end else begin
        stall_cnt_nxt_s = stall_cnt_r + STALL_ONE;
      end
    end else begin
      stall_cnt_nxt_s = {SW{1'b0}};
    end
    stall_nxt_s = (stall_cnt_nxt_s == STALL_MAX);
  end

  // FIFO storage; cleared on reset so no stale flit survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      ovf_err_r   <= 1'b0;
      stall_cnt_r <= {SW{1'b0}};
      stall_r     <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r     <= count_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      ovf_err_r   <= ovf_err_r || ovf_s;
      stall_cnt_r <= stall_cnt_nxt_s;
      stall_r     <= stall_nxt_s;
    end
  end

  assign full_ret  = full_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign count     = count_r;
  assign ovf_err   = ovf_err_r;
  assign stall     = stall_r;

endmodule

// File: tb/tb_noc_output_port_buf.sv
// Scoreboard bench for noc_output_port_buf: queue-level reference model plus a
// separate link monitor that checks every flit transferred to the neighbour.
module tb_noc_output_port_buf;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LIMIT = 16;
  localparam int CW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          ret;
  logic          ret_z;

  logic          full_ret, out_valid, ovf_err, stall;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          full_ret_z, out_valid_z, ovf_err_z, stall_z;
  logic [DW-1:0] out_data_z;
  logic [CW-1:0] count_z;

  noc_output_port_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ZERO_IDLE(1), .STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .full_ret(full_ret),
    .ret(ret), .out_data(out_data), .out_valid(out_valid), .count(count),
    .ovf_err(ovf_err), .stall(stall)
  );

  noc_output_port_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ZERO_IDLE(0), .STALL_LIMIT(LIMIT)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .full_ret(full_ret_z),
    .ret(ret_z), .out_data(out_data_z), .out_valid(out_valid_z), .count(count_z),
    .ovf_err(ovf_err_z), .stall(stall_z)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model of the ZERO_IDLE=1 instance: occupancy, output-valid, flags,
  // and the queue of accepted flits still owed to the neighbour.
  int            m_cnt;
  bit            m_ov;
  bit            m_ovf;
  int            m_scnt;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input int act, input int want);
    vec_cnt++;
    if (act !== want) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic void model_reset();
    m_cnt  = 0;
    m_ov   = 1'b0;
    m_ovf  = 1'b0;
    m_scnt = 0;
    exp_q.delete();
  endfunction

  function automatic void model_step();
    bit full, zero, free;
    full = (m_cnt == DEPTH);
    zero = (in_data == '0);
    if (m_ov && ret) m_scnt = (m_scnt < LIMIT) ? m_scnt + 1 : LIMIT;
    else m_scnt = 0;
    if (in_valid && !zero && full) m_ovf = 1'b1;
    free = !m_ov || !ret;
    if (free) begin
      if (m_cnt > 0) begin
        m_cnt--;
        m_ov = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
    end
    if (in_valid && !zero && !full) begin
      m_cnt++;
      exp_q.push_back(in_data);
    end
  endfunction

  // Model: compare state left by the last edge, then predict the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      chk("count",     int'(count),     m_cnt);
      chk("full_ret",  int'(full_ret),  int'(m_cnt == DEPTH));
      chk("out_valid", int'(out_valid), int'(m_ov));
      chk("ovf_err",   int'(ovf_err),   int'(m_ovf));
      chk("stall",     int'(stall),     int'(m_scnt == LIMIT));
      model_step();
    end
  end

  // Link monitor: every flit the neighbour takes must be the oldest one owed.
  always @(negedge clk) begin
    if (!rst && out_valid && !ret) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_flit: got 0x%0h, want no transfer at %0t", out_data, $time);
      end else begin
        chk("flit", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
    in_valid = v;
    in_data  = d;
    ret      = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit rmode_hold;
    bit rmode_free;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; ret = 1'b0; ret_z = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom); in_data = 8'($urandom); ret = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_out_valid", int'(out_valid), 0);
    in_valid = 1'b0; in_data = '0; ret = 1'b0; rst = 1'b0;
    chk("rel_out_valid", int'(out_valid), 0);
    chk("rel_out_data",  int'(out_data),  0);
    chk("rel_count",     int'(count),     0);
    chk("rel_full_ret",  int'(full_ret),  0);
    chk("rel_ovf_err",   int'(ovf_err),   0);
    chk("rel_stall",     int'(stall),     0);

    // latency
    drive(1'b1, 8'hA5, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("lat_valid", int'(out_valid), 1);
    chk("lat_data",  int'(out_data),  'hA5);
    drive(1'b0, 8'h00, 1'b0);
    chk("lat_idle", int'(out_valid), 0);

    // backpressure fill, overflow, stall
    for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i), 1'b1);
    chk("fill_count", int'(count),     4);
    chk("fill_full",  int'(full_ret),  1);
    chk("fill_head",  int'(out_data),  1);
    chk("fill_valid", int'(out_valid), 1);
    drive(1'b1, 8'h77, 1'b1);
    chk("ovf_set",   int'(ovf_err), 1);
    chk("ovf_count", int'(count),   4);
    for (int i = 0; i < 11; i++) drive(1'b0, 8'h00, 1'b1);
    chk("stall_15", int'(stall), 0);
    drive(1'b0, 8'h00, 1'b1);
    chk("stall_16", int'(stall), 1);
    for (int i = 1; i <= 5; i++) begin
      chk("drain_valid", int'(out_valid), 1);
      chk("drain_data",  int'(out_data),  i);
      drive(1'b0, 8'h00, 1'b0);
      if (i == 1) chk("stall_clear", int'(stall), 0);
    end
    chk("drain_idle",  int'(out_valid), 0);
    chk("drain_count", int'(count),     0);
    chk("ovf_sticky",  int'(ovf_err),   1);

    // zero-as-idle encoding vs plain valid qualification
    drive(1'b1, 8'h00, 1'b0);
    chk("zi_count",   int'(count),   0);
    chk("zi0_count",  int'(count_z), 1);
    drive(1'b0, 8'h00, 1'b0);
    chk("zi_valid",   int'(out_valid),   0);
    chk("zi0_valid",  int'(out_valid_z), 1);
    chk("zi0_data",   int'(out_data_z),  0);
    drive(1'b0, 8'h00, 1'b0);

    // randomized traffic with ret held, released or toggling in bursts
    for (int b = 0; b < 16; b++) begin
      rmode_hold = 1'($urandom_range(0, 2) == 0);
      rmode_free = 1'($urandom_range(0, 1));
      for (int c = 0; c < 24; c++) begin
        drive(1'($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
              rmode_hold ? 1'b1 : (rmode_free ? 1'b0 : 1'($urandom)));
      end
    end
    for (int c = 0; c < 20 && (exp_q.size() != 0 || out_valid); c++) drive(1'b0, 8'h00, 1'b0);
    chk("rand_drained", exp_q.size(), 0);

    // reset mid-traffic
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i * 17), 1'b1);
    chk("mid_count", int'(count),     3);
    chk("mid_valid", int'(out_valid), 1);
    in_valid = 1'b0; in_data = '0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data",  int'(out_data),  0);
    chk("mid_rst_count", int'(count),     0);
    chk("mid_rst_ovf",   int'(ovf_err),   0);
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b0);
    chk("post_rst_idle", int'(out_valid), 0);
    drive(1'b1, 8'h5A, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("post_rst_data", int'(out_data), 'h5A);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("final_empty", exp_q.size(), 0);
    chk("zi0_ovf",     int'(ovf_err_z),  0);
    chk("zi0_stall",   int'(stall_z),    0);
    chk("zi0_full",    int'(full_ret_z), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
